// File: rtl/mfda_valve_pkg.sv
// Shared types, constants and the MUX8 path-pattern helper for valve sequencers.
package mfda_valve_pkg;

    localparam int unsigned AIR_W = 6;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLOSE,
        OPEN,
        DWELL,
        DONE
    } state_t;

    localparam logic [AIR_W-1:0] ALL_CLOSED = 6'b111111;

    // Each select bit opens exactly one member of its control pair (0 = open).
    function automatic logic [AIR_W-1:0] mux8_pattern(input logic [SEL_W-1:0] sel);
        return {~sel[2], sel[2], ~sel[1], sel[1], ~sel[0], sel[0]};
    endfunction

endpackage

// File: rtl/valve_timer.sv
// Loadable down-counter: holds a load value and flags its last cycle (count == 1).
module valve_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired_c
);

    logic [W-1:0] count;

    // Reload on demand, otherwise count down and park at 1 so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count > W'(1)) begin
            count <= count - W'(1);
        end
    end

    // Last cycle of the loaded interval.
    always_comb begin
        expired_c = (count == W'(1));
    end

endmodule

// File: rtl/mux8_valve_sequencer.sv
// Break-before-make air sequencer for the 8:1 fluidic multiplexer control lines.
module mux8_valve_sequencer
    import mfda_valve_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 100,
    parameter int unsigned DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_sel,
    input  logic [DWELL_W-1:0] req_dwell,
    input  logic               abort,
    output logic [AIR_W-1:0]   air,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [SEL_W-1:0]   active_sel
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned CNT_W    = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;

    state_t             state;
    state_t             state_d;
    logic [DWELL_W-1:0] dwell_q;
    logic               accept_c;
    logic               aborted_d;
    logic               load_c;
    logic [CNT_W-1:0]   load_val_c;
    logic               expired_c;
    logic [AIR_W-1:0]   air_d;

    valve_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .value    (load_val_c),
        .expired_c(expired_c)
    );

    // Next state, timer reload and next registered output values.
    always_comb begin
        state_d    = state;
        accept_c   = 1'b0;
        aborted_d  = 1'b0;
        load_c     = 1'b0;
        load_val_c = '0;
        air_d      = ALL_CLOSED;

        if (state != IDLE && abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready && !abort) begin
                        accept_c = 1'b1;
                        state_d  = CLOSE;
                    end
                end
                CLOSE: if (expired_c) state_d = OPEN;
                OPEN: begin
                    if (expired_c) state_d = (dwell_q == '0) ? DONE : DWELL;
                end
                DWELL: if (expired_c) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Every state entry restarts the timer with that state's interval.
        load_c = (state_d != state);
        case (state_d)
            CLOSE, OPEN: load_val_c = CNT_W'(SETTLE_CYC);
            DWELL:       load_val_c = CNT_W'(dwell_q);
            default:     load_val_c = '0;
        endcase

        if (state_d == OPEN || state_d == DWELL) begin
            air_d = mux8_pattern(active_sel);
        end
    end

    // State register, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            air        <= ALL_CLOSED;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            active_sel <= '0;
            dwell_q    <= '0;
        end else begin
            state     <= state_d;
            air       <= air_d;
            req_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
            aborted   <= aborted_d;
            if (accept_c) begin
                active_sel <= req_sel;
                dwell_q    <= req_dwell;
            end
        end
    end

endmodule

// File: tb/tb_mux8_valve_sequencer.sv
// Scoreboard bench: timing-formula reference model, pulse queue and per-cycle output checks.
module tb_mux8_valve_sequencer;

    localparam int unsigned S  = 4;
    localparam int unsigned DW = 6;

    typedef struct {
        bit         is_abort;
        int         cyc;
        logic [2:0] sel;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_sel = '0;
    logic [DW-1:0] req_dwell = '0;
    logic          abort = 1'b0;
    logic [5:0]    air;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [2:0]    active_sel;

    int errors = 0;
    int checks = 0;

    // Reference model state, advanced once per clock edge.
    int         cyc = 0;
    bit         chk_en = 1'b0;
    bit         m_active = 1'b0;
    int         m_t0 = 0;
    int         m_last = 0;
    int         m_phase = 0;
    logic [2:0] m_sel = '0;
    logic [2:0] exp_sel = '0;
    ev_t        sb[$];
    int         c0 = 0;

    mux8_valve_sequencer #(
        .SETTLE_CYC(S),
        .DWELL_W   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_dwell (req_dwell),
        .abort     (abort),
        .air       (air),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .active_sel(active_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] exp_pattern(input logic [2:0] s);
        logic [5:0] a;
        for (int i = 0; i < 3; i++) begin
            a[2*i]   = s[i];
            a[2*i+1] = ~s[i];
        end
        return a;
    endfunction

    // Model: interval after edge e has phase e - t0 + 1; a sequence spans phases 1..2S+D+1.
    always @(posedge clk) begin : model
        int k;
        cyc++;
        if (rst) begin
            if (m_active && (cyc - m_t0) < m_last) sb.delete(sb.size() - 1);
            m_active = 1'b0;
            exp_sel  = '0;
            chk_en   = 1'b1;
        end else if (m_active) begin
            k = cyc - m_t0;
            if (k >= m_last) begin
                m_active = 1'b0;
            end else if (abort) begin
                sb.delete(sb.size() - 1);
                sb.push_back('{1'b1, cyc, m_sel});
                m_active = 1'b0;
            end
        end else if (req_valid && !abort) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_sel    = req_sel;
            m_last   = 2 * int'(S) + int'(req_dwell) + 1;
            exp_sel  = req_sel;
            sb.push_back('{1'b0, cyc + m_last - 1, req_sel});
        end
        m_phase = m_active ? (cyc - m_t0 + 1) : 0;
    end

    // Monitor: compare levels every cycle, pop the scoreboard on each pulse.
    always @(negedge clk) begin : monitor
        logic [5:0] ea;
        ev_t        ev;
        if (chk_en) begin
            ea = 6'b111111;
            if (m_active && m_phase > int'(S) && m_phase < m_last) ea = exp_pattern(m_sel);
            chk("air", 32'(air), 32'(ea));
            chk("busy", 32'(busy), 32'(m_active));
            chk("req_ready", 32'(req_ready), 32'(!m_active));
            chk("active_sel", 32'(active_sel), 32'(exp_sel));
            chk("done_aborted_excl", 32'(done & aborted), 32'd0);
            for (int i = 0; i < 3; i++) chk("pair_open_excl", 32'(air[2*i] | air[2*i+1]), 32'd1);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                ev = sb.pop_front();
                chk("missed_pulse_cycle", 32'(cyc), 32'(ev.cyc));
            end
            if (done || aborted) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b aborted=%0b expected none (cycle %0d)",
                             done, aborted, cyc);
                end else begin
                    ev = sb.pop_front();
                    chk("pulse_kind_aborted", 32'(aborted), 32'(ev.is_abort));
                    chk("pulse_cycle", 32'(cyc), 32'(ev.cyc));
                    chk("pulse_sel", 32'(active_sel), 32'(ev.sel));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] s, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_sel   = s;
        req_dwell = d;
        tick(1);
        req_valid = 1'b0;
        c0 = cyc;
    endtask

    // Sample inside cycle k (cycle 1 follows the accept edge).
    task automatic wait_cycle(input int k);
        while (cyc < c0 + k - 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        tick(1);
    endtask

    initial begin
        int last;
        int n;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_air", 32'(air), 32'h3f);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        tick(1);

        // sel=0, D=3
        issue(3'd0, 6'd3);
        wait_cycle(4);  chk("s0_closed_c4", 32'(air), 32'h3f);
        wait_cycle(5);  chk("s0_open_c5", 32'(air), 32'b101010);
        wait_cycle(11); chk("s0_open_c11", 32'(air), 32'b101010);
        wait_cycle(12); chk("s0_done_c12", 32'(done), 32'd1);
        wait_cycle(13); chk("s0_ready_c13", 32'(req_ready), 32'd1);
        drain();

        // sel=5, D=0 then sel=7
        issue(3'd5, 6'd0);
        wait_cycle(5); chk("s5_open_c5", 32'(air), 32'b011001);
        wait_cycle(8); chk("s5_open_c8", 32'(air), 32'b011001);
        wait_cycle(9); chk("s5_done_c9", 32'(done), 32'd1);
        drain();
        issue(3'd7, 6'd0);
        wait_cycle(5); chk("s7_open_c5", 32'(air), 32'b010101);
        drain();

        // Abort during cycle 6 of a sel=2 sequence
        issue(3'd2, 6'd5);
        tick(5);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_air", 32'(air), 32'h3f);
        chk("abort_pulse", 32'(aborted), 32'd1);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        drain();

        // Abort together with a request in IDLE
        req_valid = 1'b1;
        abort     = 1'b1;
        tick(1);
        req_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_ready", 32'(req_ready), 32'd1);
        tick(1);

        // Reset in DWELL
        issue(3'd3, 6'd5);
        tick(2 * S + 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dwell_air", 32'(air), 32'h3f);
        chk("rst_dwell_done", 32'(done), 32'd0);
        chk("rst_dwell_aborted", 32'(aborted), 32'd0);
        tick(1);

        // Maximum dwell, sel=6
        issue(3'd6, 6'h3f);
        wait_cycle(2 * S + 63); chk("maxd_open_last", 32'(air), 32'b010110);
        wait_cycle(2 * S + 64); chk("maxd_done", 32'(done), 32'd1);
        drain();

        // Request held high: ready windows spaced by 2S+D+2
        req_valid = 1'b1;
        req_dwell = 6'd2;
        last = -1;
        n = 0;
        for (int t = 0; t < 200 && n < 4; t++) begin
            @(negedge clk);
            req_sel = 3'($urandom);
            if (req_ready) begin
                if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'(2 * S + 2 + 2));
                last = cyc;
                n++;
            end
        end
        chk("b2b_count", 32'(n), 32'd4);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();

        // Randomized traffic with occasional abort and reset
        for (int t = 0; t < 2500; t++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_sel   = 3'($urandom);
            req_dwell = ($urandom_range(0, 15) == 0) ? 6'h3f : 6'($urandom_range(0, 5));
            abort     = ($urandom_range(0, 29) == 0) && !(m_active && m_phase == m_last);
            rst       = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        req_valid = 1'b0;
        abort     = 1'b0;
        rst       = 1'b0;
        drain();
        @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux8_valve_sequencer.md
# mux8_valve_sequencer

Clocked pneumatic controller that drives the six air-control lines of the 8:1 fluidic multiplexer (MUX8) feeding the logic array. It accepts a channel-select request over a valid/ready handshake. It then runs a break-before-make sequence: close all valves, wait for settling, open the selected path, and hold it for a requested dwell. It reports completion with a one-cycle pulse. It sits between the host command path and the off-chip solenoid bank that pressurizes c1..c6.

## Interface
Parameters:
- SETTLE_CYC, 100, cycles each valve transition must settle (≥1)
- DWELL_W, 16, width of dwell count

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_sel  in  3  MUX8 channel 0..7 (i1..i8)
- req_dwell  in  DWELL_W  extra cycles to hold path open after settle
- abort  in  1  terminate current sequence
- air  out  6  air[k] drives c(k+1); 1 = pressurized = valve closed
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at normal completion
- aborted  out  1  one-cycle pulse when abort takes effect
- active_sel  out  3  latched channel of current/last sequence

## Operation
- Default path pattern for channel n (0 = open):
  - air[0] = n[0], air[1] = ~n[0]
  - air[2] = n[1], air[3] = ~n[1]
  - air[4] = n[2], air[5] = ~n[2]
- ALL_CLOSED = 6'b111111.
- States:
  - IDLE: air = ALL_CLOSED, req_ready = 1, busy = 0. When req_valid & req_ready, latch sel and dwell, then go to CLOSE.
  - CLOSE: air = ALL_CLOSED for SETTLE_CYC cycles, then go to OPEN.
  - OPEN: air = pattern(sel) for SETTLE_CYC cycles, then go to DWELL, or to DONE if the latched dwell is 0.
  - DWELL: air = pattern(sel) for the latched dwell cycles, then go to DONE.
  - DONE: air = ALL_CLOSED, done = 1 for one cycle, then go to IDLE.
- busy = 1 in every state except IDLE.
- req_ready = 0 outside IDLE. Requests are never queued.
- Abort:
  - Sampled high in any non-IDLE state: next cycle is IDLE with air = ALL_CLOSED and aborted = 1 for that cycle. No done pulse.
  - Abort in IDLE is ignored, but it blocks acceptance that cycle: the request is not taken and req_ready stays high.
- Reset: air = ALL_CLOSED, state IDLE, busy/done/aborted = 0, active_sel = 0, counters cleared.
  - Reset mid-sequence discards the sequence silently, with no aborted pulse.
- Counter is DWELL_W or clog2(SETTLE_CYC+1) wide, whichever is larger. It is reloaded on every state entry and counts down to 1. No wrap is possible.
- A maximum dwell (all ones) holds the path for exactly 2^DWELL_W − 1 cycles.
- No two states ever drive both air[2k] and air[2k+1] low. Only a single pair member is open at any time.

## Timing
- Request accepted at edge E0. Let S = SETTLE_CYC and D = dwell.
- Cycles 1..S: ALL_CLOSED.
- Cycles S+1..2S+D: pattern(sel).
- Cycle 2S+D+1: DONE (air closed, done = 1).
- Cycle 2S+D+2: IDLE, req_ready = 1.
- active_sel updates in cycle 1 and holds until the next accept.
- Outputs are registered; no combinational path from inputs to air.

## Structure
- Package mfda_valve_pkg contains:
  - state enum (IDLE, CLOSE, OPEN, DWELL, DONE)
  - ALL_CLOSED constant
  - function mux8_pattern(sel) returning the 6-bit air word
- Sub-module valve_timer holds the loadable down-counter with a load/expire interface. It is reused by the planned logic-array (c1..c23) sequencer.

## Test plan
- Reset with S=4, D=3: air=6'b111111, req_ready=1, busy=0. Request sel=0 -> air=6'b111111 cycles 1–4, air=6'b101010 cycles 5–11, done=1 at cycle 12, req_ready=1 at 13.
- sel=5, D=0, S=4 -> air=6'b011001 cycles 5–8, done at cycle 9. sel=7 -> 6'b010101.
- Abort asserted at cycle 6 of a sel=2 sequence -> air=6'b111111 and aborted=1 at cycle 7, done never asserted, req_ready=1 at cycle 7.
- Request held high during busy -> no second accept until IDLE. Back-to-back requests are spaced by exactly 2S+D+2 cycles, and active_sel tracks each one.
- abort and req_valid high together in IDLE -> no accept, busy stays 0. rst mid-DWELL -> next cycle air=6'b111111, no done/aborted pulse.
- Assertion across random sel, dwell, and abort: never air[2k]=0 and air[2k+1]=0 simultaneously. done and aborted are never high together.
